riscv_v_wb_pipe: RTL and testbench

//  Vector back-end write pipeline: takes EXE results, builds per-byte RF write enables from

---
 rtl/riscv_v_pkg.sv | 22 ++
 rtl/riscv_v_byte_en_gen.sv | 48 ++++
 rtl/riscv_v_wb_pipe.sv | 102 ++++++++++
 tb/tb_riscv_v_wb_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
// Shared vector-unit constants and the one-hot element-size encoding used by
// the vector write-back pipeline.
package riscv_v_pkg;

    localparam int unsigned RISCV_V_DATA_WIDTH       = 128;
    localparam int unsigned RISCV_V_NUM_BYTES_DATA   = RISCV_V_DATA_WIDTH / 8;
    localparam int unsigned RISCV_V_NUM_VALID_OSIZES = 5;
    localparam int unsigned RISCV_V_VL_WIDTH         = $clog2(RISCV_V_NUM_BYTES_DATA + 1);

    // v0 is the architectural mask register
    localparam int unsigned RISCV_V_MASK_RF_POS      = 0;

    // bit k set = element of 2^k bytes
    typedef enum logic [RISCV_V_NUM_VALID_OSIZES-1:0] {
        OSIZE_8B   = 5'b00001,
        OSIZE_16B  = 5'b00010,
        OSIZE_32B  = 5'b00100,
        OSIZE_64B  = 5'b01000,
        OSIZE_128B = 5'b10000
    } riscv_v_osize_e;

endpackage

// File: rtl/riscv_v_byte_en_gen.sv
// Combinational byte-enable generator: maps element size, vl and the v0 mask
// onto per-byte register-file write enables.
module riscv_v_byte_en_gen
    import riscv_v_pkg::*;
#(
    parameter int unsigned NBYTES = RISCV_V_NUM_BYTES_DATA,
    parameter int unsigned VL_W   = RISCV_V_VL_WIDTH
) (
    input  logic                                valid,
    input  logic [RISCV_V_NUM_VALID_OSIZES-1:0] osize_vector,
    input  logic [VL_W-1:0]                     vl,
    input  logic                                vm,
    input  logic [NBYTES-1:0]                   mask,
    output logic [NBYTES-1:0]                   byte_en
);

    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [2:0] osize_ones;
    logic [2:0] osize_idx;
    logic       osize_ok;

    always_comb begin
        osize_ones = '0;
        osize_idx  = '0;
        for (int unsigned i = 0; i < RISCV_V_NUM_VALID_OSIZES; i++) begin
            if (osize_vector[i]) begin
                osize_ones = osize_ones + 3'd1;
                osize_idx  = i[2:0];
            end
        end
        osize_ok = (osize_ones == 3'd1);
    end

    // vl above the element count needs no explicit clamp: every element index
    // reachable from a byte lane is already below NBYTES>>k.
    always_comb begin
        byte_en = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            int unsigned elem;
            elem = b >> osize_idx;
            if (osize_ok && valid && (elem < 32'(vl)) && (vm || mask[elem[IDX_W-1:0]])) begin
                byte_en[b] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_v_wb_pipe.sv
// Vector write-back pipeline: EXE byte-enable generation plus MEM and WB register
// slices feeding the bypass network and RF write port. Optional RISCV_V_WB_STATS_EN.
module riscv_v_wb_pipe
    import riscv_v_pkg::*;
#(
    parameter int unsigned DATA_W = RISCV_V_DATA_WIDTH,
    parameter int unsigned NBYTES = DATA_W / 8,
    parameter int unsigned VL_W   = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                exe_valid,
    input  logic [4:0]                          exe_rd_addr,
    input  logic [DATA_W-1:0]                   exe_result,
    input  logic [RISCV_V_NUM_VALID_OSIZES-1:0] exe_osize_vector,
    input  logic [VL_W-1:0]                     exe_vl,
    input  logic                                exe_vm,
    input  logic [NBYTES-1:0]                   exe_mask,
    input  logic                                stall,
    input  logic                                flush,
    output logic [NBYTES-1:0]                   rf_wr_en_mem,
    output logic [4:0]                          rf_wr_addr_mem,
    output logic [DATA_W-1:0]                   rf_wr_data_mem,
    output logic [NBYTES-1:0]                   rf_wr_en_wb,
    output logic [4:0]                          rf_wr_addr_wb,
    output logic [DATA_W-1:0]                   rf_wr_data_wb
`ifdef RISCV_V_WB_STATS_EN
    ,
    output logic [31:0]                         stat_wr_cnt,
    output logic [31:0]                         stat_byte_cnt
`endif
);

    logic [NBYTES-1:0] exe_byte_en;

    riscv_v_byte_en_gen #(
        .NBYTES (NBYTES),
        .VL_W   (VL_W)
    ) u_byte_en_gen (
        .valid        (exe_valid),
        .osize_vector (exe_osize_vector),
        .vl           (exe_vl),
        .vm           (exe_vm),
        .mask         (exe_mask),
        .byte_en      (exe_byte_en)
    );

    // Flush only clears the MEM enables; it still beats stall so a squashed
    // instruction cannot linger in MEM while the pipe is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en_mem   <= '0;
            rf_wr_addr_mem <= '0;
            rf_wr_data_mem <= '0;
        end else begin
            if (flush) begin
                rf_wr_en_mem <= '0;
            end else if (!stall) begin
                rf_wr_en_mem <= exe_byte_en;
            end
            if (!stall) begin
                rf_wr_addr_mem <= exe_rd_addr;
                rf_wr_data_mem <= exe_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en_wb   <= '0;
            rf_wr_addr_wb <= '0;
            rf_wr_data_wb <= '0;
        end else if (!stall) begin
            rf_wr_en_wb   <= rf_wr_en_mem;
            rf_wr_addr_wb <= rf_wr_addr_mem;
            rf_wr_data_wb <= rf_wr_data_mem;
        end
    end

`ifdef RISCV_V_WB_STATS_EN
    logic [31:0] wb_byte_pop;

    always_comb begin
        wb_byte_pop = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            wb_byte_pop = wb_byte_pop + 32'(rf_wr_en_wb[b]);
        end
    end

    // A write held through a stall is counted once, on the cycle it retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wr_cnt   <= '0;
            stat_byte_cnt <= '0;
        end else if (!stall && (rf_wr_en_wb != '0)) begin
            stat_wr_cnt   <= stat_wr_cnt + 32'd1;
            stat_byte_cnt <= stat_byte_cnt + wb_byte_pop;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_v_wb_pipe.sv
// Scoreboard bench for riscv_v_wb_pipe: directed cases followed by random traffic,
// checked against a transaction-level model of the MEM/WB pipeline.
module tb_riscv_v_wb_pipe;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned NBYTES = 16;
    localparam int unsigned VL_W   = 5;

    localparam int K_RESET = 0;
    localparam int K_ADV   = 1;
    localparam int K_HOLD  = 2;
    localparam int K_FHOLD = 3;

    typedef struct {
        int                kind;
        logic [NBYTES-1:0] en;
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } rec_t;

    logic              clk = 1'b0;
    logic              rst, exe_valid, exe_vm, stall, flush;
    logic [4:0]        exe_rd_addr, exe_osize_vector;
    logic [DATA_W-1:0] exe_result;
    logic [VL_W-1:0]   exe_vl;
    logic [NBYTES-1:0] exe_mask;
    logic [NBYTES-1:0] rf_wr_en_mem, rf_wr_en_wb;
    logic [4:0]        rf_wr_addr_mem, rf_wr_addr_wb;
    logic [DATA_W-1:0] rf_wr_data_mem, rf_wr_data_wb;
`ifdef RISCV_V_WB_STATS_EN
    logic [31:0]       stat_wr_cnt, stat_byte_cnt;
`endif

    int total = 0;
    int bad   = 0;
    rec_t sb_q[$];

    always #5 clk = ~clk;

    riscv_v_wb_pipe #(
        .DATA_W (DATA_W),
        .NBYTES (NBYTES),
        .VL_W   (VL_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .exe_valid        (exe_valid),
        .exe_rd_addr      (exe_rd_addr),
        .exe_result       (exe_result),
        .exe_osize_vector (exe_osize_vector),
        .exe_vl           (exe_vl),
        .exe_vm           (exe_vm),
        .exe_mask         (exe_mask),
        .stall            (stall),
        .flush            (flush),
        .rf_wr_en_mem     (rf_wr_en_mem),
        .rf_wr_addr_mem   (rf_wr_addr_mem),
        .rf_wr_data_mem   (rf_wr_data_mem),
        .rf_wr_en_wb      (rf_wr_en_wb),
        .rf_wr_addr_wb    (rf_wr_addr_wb),
        .rf_wr_data_wb    (rf_wr_data_wb)
`ifdef RISCV_V_WB_STATS_EN
        ,
        .stat_wr_cnt      (stat_wr_cnt),
        .stat_byte_cnt    (stat_byte_cnt)
`endif
    );

    // Reference: element size 2^k bytes, active elements = min(vl, 16 >> k).
    function automatic logic [NBYTES-1:0] ref_en(input logic v, input logic [4:0] os,
                                                 input int vl, input logic vm,
                                                 input logic [NBYTES-1:0] m);
        logic [NBYTES-1:0] r;
        int ones, k, esz, nel, act;
        r = '0; ones = 0; k = 0;
        for (int i = 0; i < 5; i++) if (os[i]) begin ones++; k = i; end
        if (!v || ones != 1) return r;
        esz = 1 << k;
        nel = NBYTES / esz;
        act = (vl < nel) ? vl : nel;
        for (int el = 0; el < act; el++)
            if (vm || m[el])
                for (int j = 0; j < esz; j++) r[el*esz + j] = 1'b1;
        return r;
    endfunction

    task automatic apply(input logic r, input logic s, input logic f, input logic v,
                         input logic [4:0] rd, input logic [DATA_W-1:0] d,
                         input logic [4:0] os, input logic [VL_W-1:0] vl,
                         input logic vm, input logic [NBYTES-1:0] m);
        rec_t rc;
        rst = r; stall = s; flush = f; exe_valid = v; exe_rd_addr = rd;
        exe_result = d; exe_osize_vector = os; exe_vl = vl; exe_vm = vm; exe_mask = m;
        rc.en = '0; rc.addr = rd; rc.data = d;
        if (r)       rc.kind = K_RESET;
        else if (!s) begin
            rc.kind = K_ADV;
            if (!f) rc.en = ref_en(v, os, int'(vl), vm, m);
        end
        else if (f)  rc.kind = K_FHOLD;
        else         rc.kind = K_HOLD;
        sb_q.push_back(rc);
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic v,
                        input logic [4:0] rd, input logic [DATA_W-1:0] d,
                        input logic [4:0] os, input logic [VL_W-1:0] vl,
                        input logic vm, input logic [NBYTES-1:0] m);
        @(negedge clk);
        apply(r, s, f, v, rd, d, os, vl, vm, m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, '0, 5'b00001, 5'd0, 1'b1, '0);
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one record per clock edge, applied to the expected stage contents.
    initial begin : monitor
        logic [NBYTES-1:0] m_en, w_en;
        logic [4:0]        m_addr, w_addr;
        logic [DATA_W-1:0] m_data, w_data;
        logic              m_chk, w_chk;
        logic [31:0]       s_wr, s_byte;
        rec_t rc;
        m_en = '0; w_en = '0; m_addr = '0; w_addr = '0; m_data = '0; w_data = '0;
        m_chk = 1'b0; w_chk = 1'b0; s_wr = '0; s_byte = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
                continue;
            end
            rc = sb_q.pop_front();
            case (rc.kind)
                K_RESET: begin
                    m_en = '0; w_en = '0; m_addr = '0; w_addr = '0;
                    m_data = '0; w_data = '0; m_chk = 1'b1; w_chk = 1'b1;
                    s_wr = '0; s_byte = '0;
                end
                K_ADV: begin
                    if (w_en != '0) begin
                        s_wr = s_wr + 1;
                        s_byte = s_byte + 32'($countones(w_en));
                    end
                    w_en = m_en; w_addr = m_addr; w_data = m_data; w_chk = m_chk;
                    m_en = rc.en; m_addr = rc.addr; m_data = rc.data; m_chk = (rc.en != '0);
                end
                K_FHOLD: begin
                    m_en = '0; m_chk = 1'b0;
                end
                default: ;
            endcase
            check("en_mem", DATA_W'(rf_wr_en_mem), DATA_W'(m_en));
            check("en_wb",  DATA_W'(rf_wr_en_wb),  DATA_W'(w_en));
            if (m_chk) begin
                check("addr_mem", DATA_W'(rf_wr_addr_mem), DATA_W'(m_addr));
                check("data_mem", rf_wr_data_mem, m_data);
            end
            if (w_chk) begin
                check("addr_wb", DATA_W'(rf_wr_addr_wb), DATA_W'(w_addr));
                check("data_wb", rf_wr_data_wb, w_data);
            end
`ifdef RISCV_V_WB_STATS_EN
            check("stat_wr_cnt",   DATA_W'(stat_wr_cnt),   DATA_W'(s_wr));
            check("stat_byte_cnt", DATA_W'(stat_byte_cnt), DATA_W'(s_byte));
`endif
        end
    end

    initial begin : stim
        logic [DATA_W-1:0] seq_data, rd_data;
        logic [4:0]        r_rd, r_os;
        logic [VL_W-1:0]   r_vl;
        logic [NBYTES-1:0] r_mask;
        logic              r_v, r_vm, r_s, r_f, r_r;
        seq_data = 128'h0F0E0D0C0B0A09080706050403020100;
        apply(1, 0, 0, 0, 5'd0, '0, 5'b00001, 5'd0, 1'b1, '0);
        step(1, 0, 0, 0, 5'd0, '0, 5'b00001, 5'd0, 1'b1, '0);
        // 8b elements, full vl
        step(0, 0, 0, 1, 5'd3, seq_data, 5'b00001, 5'd16, 1'b1, '0);
        idle(2);
        // 32b masked, 64b clamped, multi-hot osize, vl = 0
        step(0, 0, 0, 1, 5'd4, {4{32'hDEADBEEF}}, 5'b00100, 5'd3, 1'b0, 16'h0005);
        step(0, 0, 0, 1, 5'd5, {4{32'h12345678}}, 5'b01000, 5'd7, 1'b1, '0);
        step(0, 0, 0, 1, 5'd6, {4{32'hA5A5A5A5}}, 5'b00011, 5'd16, 1'b1, '0);
        step(0, 0, 0, 1, 5'd7, {4{32'h5A5A5A5A}}, 5'b00001, 5'd0, 1'b1, '0);
        step(0, 0, 0, 1, 5'd8, {4{32'h01020304}}, 5'b10000, 5'd1, 1'b1, '0);
        idle(2);
        // stall three cycles with writes in MEM and WB, then release
        step(0, 0, 0, 1, 5'd9,  {4{32'h11111111}}, 5'b00010, 5'd8, 1'b1, '0);
        step(0, 0, 0, 1, 5'd10, {4{32'h22222222}}, 5'b00010, 5'd5, 1'b1, '0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 1, 5'd11, {4{32'h33333333}}, 5'b00001, 5'd16, 1'b1, '0);
        step(0, 0, 0, 1, 5'd11, {4{32'h33333333}}, 5'b00001, 5'd16, 1'b1, '0);
        idle(2);
        // flush a valid write while another is heading to WB; then flush under stall
        step(0, 0, 0, 1, 5'd12, {4{32'h44444444}}, 5'b00001, 5'd16, 1'b1, '0);
        step(0, 0, 1, 1, 5'd13, {4{32'h55555555}}, 5'b00001, 5'd16, 1'b1, '0);
        step(0, 0, 0, 1, 5'd14, {4{32'h66666666}}, 5'b00001, 5'd16, 1'b1, '0);
        step(0, 1, 1, 1, 5'd14, {4{32'h66666666}}, 5'b00001, 5'd16, 1'b1, '0);
        idle(2);
        // reset during a stall with writes in flight
        step(0, 0, 0, 1, 5'd15, {4{32'h77777777}}, 5'b00001, 5'd16, 1'b1, '0);
        step(0, 0, 0, 1, 5'd16, {4{32'h88888888}}, 5'b00001, 5'd16, 1'b1, '0);
        step(1, 1, 0, 1, 5'd16, {4{32'h88888888}}, 5'b00001, 5'd16, 1'b1, '0);
        idle(1);
        // random traffic; EXE held steady while stalled
        r_v = 0; r_rd = '0; rd_data = '0; r_os = 5'b00001; r_vl = '0; r_vm = 1; r_mask = '0;
        for (int n = 0; n < 400; n++) begin
            r_s = ($urandom_range(0, 99) < 20);
            r_f = ($urandom_range(0, 99) < 10);
            r_r = ($urandom_range(0, 99) < 2);
            if (!r_s) begin
                r_v = ($urandom_range(0, 99) < 80);
                r_rd = 5'($urandom);
                rd_data = {$urandom, $urandom, $urandom, $urandom};
                r_os = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
                r_vl = 5'($urandom_range(0, 20));
                r_vm = 1'($urandom);
                r_mask = 16'($urandom);
            end
            step(r_r, r_s, r_f, r_v, r_rd, rd_data, r_os, r_vl, r_vm, r_mask);
        end
        idle(3);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
